// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared widths, states and timing defaults for the NVRAM bus controller
// Wait counters are 4 bits and load (cycles - 1) on state entry.
package nvram_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam int T_ACC_DEF = 3;
  localparam int T_WP_DEF  = 3;
  localparam int T_REC_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WPULSE,
    HOLD,
    RECOV
  } nvram_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } nvram_req_t;

  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/nvram_rr_arb.sv
// rtl/nvram_rr_arb.sv - two-way round-robin arbiter
// A lone request wins outright; on contention the requester not granted last wins.
module nvram_rr_arb (
  input  logic       clk_i,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    else              grant = req;
  end

  // Reset to requester 1 so requester 0 takes the first contention.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst)          last_q <= 1'b1;
    else if (advance) last_q <= grant[1];
  end

endmodule

// File: rtl/nvram_bus_ctrl.sv
// rtl/nvram_bus_ctrl.sv - NVRAM bus controller top
// Two requesters share one asynchronous NVRAM through a SETUP/strobe/HOLD/RECOV sequence.
module nvram_bus_ctrl
  import nvram_pkg::*;
#(
  parameter int T_ACC = T_ACC_DEF,
  parameter int T_WP  = T_WP_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic              r0_we,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_ack,
  output logic              r1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_i,
  output logic              nce,
  output logic              noe,
  output logic              nwe
);

  nvram_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        grant;
  logic              start;
  logic              pick_r1;
  nvram_req_t        req_sel, req_q;
  logic              owner_q;
  logic [DATA_W-1:0] rdata_q;

  assign start   = (state_q == IDLE) && (r0_req || r1_req);
  assign pick_r1 = (grant == 2'b10);

  nvram_rr_arb u_arb (
    .clk_i   (clk_i),
    .rst     (rst),
    .req     ({r1_req, r0_req}),
    .advance (start),
    .grant   (grant)
  );

  always_comb begin
    req_sel = pick_r1 ? {r1_we, r1_addr, r1_wdata} : {r0_we, r0_addr, r0_wdata};
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (start) state_d = SETUP;
      SETUP: begin
        if (req_q.we) begin
          state_d = WPULSE;
          cnt_d   = wait_load(T_WP);
        end else begin
          state_d = ACCESS;
          cnt_d   = wait_load(T_ACC);
        end
      end
      ACCESS, WPULSE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HOLD: begin
        state_d = RECOV;
        cnt_d   = wait_load(T_REC);
      end
      RECOV: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Winner's request is frozen at IDLE->SETUP and held through RECOV.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (start) begin
        req_q   <= req_sel;
        owner_q <= pick_r1;
      end
      if (state_q == ACCESS && cnt_q == '0) rdata_q <= data_i;
    end
  end

  always_comb begin
    nce     = 1'b1;
    noe     = 1'b1;
    nwe     = 1'b1;
    data_oe = 1'b0;
    r0_ack  = 1'b0;
    r1_ack  = 1'b0;
    case (state_q)
      SETUP: begin
        nce     = 1'b0;
        data_oe = req_q.we;
      end
      ACCESS: begin
        nce = 1'b0;
        noe = 1'b0;
      end
      WPULSE: begin
        nce     = 1'b0;
        nwe     = 1'b0;
        data_oe = req_q.we;
      end
      HOLD: begin
        nce     = 1'b0;
        data_oe = req_q.we;
      end
      RECOV: begin
        if (cnt_q == '0) begin
          r0_ack = !owner_q;
          r1_ack = owner_q;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign addr   = req_q.addr;
  assign data_o = req_q.wdata;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_nvram_bus_ctrl.sv
// tb/tb_nvram_bus_ctrl.sv - scoreboard testbench for nvram_bus_ctrl
// Default-timing instance plus a T_ACC=T_WP=T_REC=1 instance.
module tb_nvram_bus_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        r0_req, r1_req, r0_we, r1_we;
  logic [12:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack, busy, data_oe, nce, noe, nwe;
  logic [7:0]  rdata, data_o, data_i;
  logic [12:0] addr;

  logic        r0_req_b, r1_req_b, r0_we_b, r1_we_b;
  logic [12:0] r0_addr_b, r1_addr_b;
  logic [7:0]  r0_wdata_b, r1_wdata_b;
  logic        r0_ack_b, r1_ack_b, busy_b, data_oe_b, nce_b, noe_b, nwe_b;
  logic [7:0]  rdata_b, data_o_b, data_i_b;
  logic [12:0] addr_b;

  nvram_bus_ctrl dut (
    .clk_i(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata), .busy(busy), .addr(addr),
    .data_o(data_o), .data_oe(data_oe), .data_i(data_i), .nce(nce), .noe(noe), .nwe(nwe)
  );

  nvram_bus_ctrl #(.T_ACC(1), .T_WP(1), .T_REC(1)) dut_fast (
    .clk_i(clk), .rst(rst),
    .r0_req(r0_req_b), .r1_req(r1_req_b), .r0_we(r0_we_b), .r1_we(r1_we_b),
    .r0_addr(r0_addr_b), .r1_addr(r1_addr_b), .r0_wdata(r0_wdata_b), .r1_wdata(r1_wdata_b),
    .r0_ack(r0_ack_b), .r1_ack(r1_ack_b), .rdata(rdata_b), .busy(busy_b), .addr(addr_b),
    .data_o(data_o_b), .data_oe(data_oe_b), .data_i(data_i_b), .nce(nce_b), .noe(noe_b), .nwe(nwe_b)
  );

  // RAM model: reads are combinational, writes land on the rising edge of nwe.
  logic [7:0] mem [0:8191];
  assign data_i   = mem[addr];
  assign data_i_b = addr_b[7:0] ^ 8'hA5;
  always @(posedge nwe) if (!rst && !nce) mem[addr] = data_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int who;
    bit rd;
    int rdat;
    int at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (r0_ack || r1_ack) begin
      chk("ack_onehot", int'(r0_ack && r1_ack), 0);
      if (q0.size() == 0) chk("ack_unexpected", 1, 0);
      else begin
        m0 = q0.pop_front();
        chk("ack_who", r1_ack ? 1 : 0, m0.who);
        chk("ack_cycle", cyc, m0.at);
        if (m0.rd) chk("ack_rdata", int'(rdata), m0.rdat);
      end
    end
  end

  always @(negedge clk) begin
    if (r0_ack_b || r1_ack_b) begin
      chk("fast_ack_onehot", int'(r0_ack_b && r1_ack_b), 0);
      if (q1.size() == 0) chk("fast_ack_unexpected", 1, 0);
      else begin
        m1 = q1.pop_front();
        chk("fast_ack_who", r1_ack_b ? 1 : 0, m1.who);
        chk("fast_ack_cycle", cyc, m1.at);
        if (m1.rd) chk("fast_ack_rdata", int'(rdata_b), m1.rdat);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input bit we, input logic [12:0] a, input logic [7:0] wd);
    if (who == 0) begin r0_we = we; r0_addr = a; r0_wdata = wd; r0_req = 1'b1; end
    else          begin r1_we = we; r1_addr = a; r1_wdata = wd; r1_req = 1'b1; end
  endtask

  // One uncontended default-timing transaction; ack expected 6 cycles after issue.
  task automatic txn(input int who, input bit we, input logic [12:0] a, input logic [7:0] wd,
                     input int exp_rd, input int drop_k,
                     output int n_ce, output int n_oe, output int n_we, output int n_doe,
                     output int n_bad);
    int c;
    c = cyc;
    n_ce = 0; n_oe = 0; n_we = 0; n_doe = 0; n_bad = 0;
    drive(who, we, a, wd);
    q0.push_back('{who, !we, exp_rd, c + 6});
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_ce  += int'(!nce);
      n_oe  += int'(!noe);
      n_we  += int'(!nwe);
      n_doe += int'(data_oe);
      if ((data_oe && data_o != wd) || (busy && addr != a) || (!nwe && nce)) n_bad++;
      if (k == drop_k) begin
        if (who == 0) r0_req = 1'b0;
        else          r1_req = 1'b0;
      end
    end
    step(1);
  endtask

  task automatic txn_fast(input int who, input bit we, input logic [12:0] a, input logic [7:0] wd,
                          input int exp_rd, input int p0, input int p1, input int p2,
                          input int p3, input int p4);
    int pat [5];
    int c;
    pat = '{p0, p1, p2, p3, p4};
    c = cyc;
    if (who == 0) begin r0_we_b = we; r0_addr_b = a; r0_wdata_b = wd; r0_req_b = 1'b1; end
    else          begin r1_we_b = we; r1_addr_b = a; r1_wdata_b = wd; r1_req_b = 1'b1; end
    q1.push_back('{who, !we, exp_rd, c + 4});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 5) chk("fast_strobes", int'({nce_b, noe_b, nwe_b}), pat[k]);
      if (k == 4) begin r0_req_b = 1'b0; r1_req_b = 1'b0; end
    end
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n_ce, n_oe, n_we, n_doe, n_bad, c;
    rst = 1'b1;
    r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
    r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0;
    r0_req_b = 0; r1_req_b = 0; r0_we_b = 0; r1_we_b = 0;
    r0_addr_b = 0; r1_addr_b = 0; r0_wdata_b = 0; r1_wdata_b = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0A5] = 8'h5A;
    mem[13'h010] = 8'h11;
    mem[13'h020] = 8'h22;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_nce", nce, 1);
    chk("rst_noe", noe, 1);
    chk("rst_nwe", nwe, 1);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_r0_ack", r0_ack, 0);
    chk("rst_r1_ack", r1_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    step(1);

    // Uncontended r0 read
    txn(0, 1'b0, 13'h0A5, 8'h00, 8'h5A, 6, n_ce, n_oe, n_we, n_doe, n_bad);
    chk("rd_nce_low", n_ce, 5);
    chk("rd_noe_low", n_oe, 3);
    chk("rd_nwe_low", n_we, 0);
    chk("rd_data_oe", n_doe, 0);
    chk("rd_stable", n_bad, 0);

    // r1 write at the top address
    txn(1, 1'b1, 13'h1FFF, 8'h3C, 0, 6, n_ce, n_oe, n_we, n_doe, n_bad);
    chk("wr_nce_low", n_ce, 5);
    chk("wr_nwe_low", n_we, 3);
    chk("wr_noe_low", n_oe, 0);
    chk("wr_data_oe", n_doe, 5);
    chk("wr_stable", n_bad, 0);
    chk("wr_mem", mem[13'h1FFF], 8'h3C);
    chk("rdata_held", rdata, 8'h5A);

    // Contention straight after reset: r0, r1, r0, r1
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    c = cyc;
    drive(0, 1'b0, 13'h010, 8'h00);
    drive(1, 1'b0, 13'h020, 8'h00);
    q0.push_back('{0, 1'b1, 8'h11, c + 6});
    q0.push_back('{1, 1'b1, 8'h22, c + 13});
    q0.push_back('{0, 1'b1, 8'h11, c + 20});
    q0.push_back('{1, 1'b1, 8'h22, c + 27});
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 20) r0_req = 1'b0;
      if (k == 27) r1_req = 1'b0;
    end
    step(1);
    chk("rr_idle_after", busy, 0);

    // r0 drops its request early; cycle completes, no second cycle
    txn(0, 1'b0, 13'h020, 8'h00, 8'h22, 2, n_ce, n_oe, n_we, n_doe, n_bad);
    chk("drop_nce_low", n_ce, 5);
    @(negedge clk);
    chk("drop_no_restart", busy, 0);
    step(1);

    // Reset during WPULSE of an r0 write, then contention goes back to r0
    drive(0, 1'b1, 13'h0777, 8'h99);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("wp_nwe_low", nwe, 0);
    #1 rst = 1'b1;
    r0_req = 1'b0;
    #1;
    chk("wp_rst_nwe", nwe, 1);
    chk("wp_rst_nce", nce, 1);
    chk("wp_rst_noe", noe, 1);
    chk("wp_rst_busy", busy, 0);
    chk("wp_rst_data_oe", data_oe, 0);
    @(posedge clk); #1 rst = 1'b0;
    c = cyc;
    drive(0, 1'b0, 13'h010, 8'h00);
    drive(1, 1'b0, 13'h020, 8'h00);
    q0.push_back('{0, 1'b1, 8'h11, c + 6});
    q0.push_back('{1, 1'b1, 8'h22, c + 13});
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 6)  r0_req = 1'b0;
      if (k == 13) r1_req = 1'b0;
    end
    step(1);
    chk("wp_mem_untouched", mem[13'h0777], 8'h00);

    // Minimum-timing instance: {nce,noe,nwe} per cycle from the IDLE sample cycle
    txn_fast(0, 1'b0, 13'h042, 8'h00, 8'hE7, 7, 3, 1, 3, 7);
    txn_fast(1, 1'b1, 13'h100, 8'h55, 0, 7, 3, 2, 3, 7);

    step(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
